// File: rtl/riscv_crypto_sbox_seq.sv
// Sequencer that time-shares NSBOX combined AES / AES^-1 / SM4 S-boxes across
// the four bytes of a 32-bit operand, trading latency for S-box count.

module riscv_crypto_aes_sm4_sbox (
  input  logic [1:0] mode_i,
  input  logic [7:0] x_i,
  output logic [7:0] y_o
);
  localparam logic [1:0] MODE_AES  = 2'b01;
  localparam logic [1:0] MODE_AESI = 2'b10;

  // SM4 has no compact algebraic form worth sharing with AES; use its table.
  localparam logic [2047:0] SM4_TAB = {
    128'hd690e9fecce13db716b614c228fb2c05,
    128'h2b679a762abe04c3aa44132649860699,
    128'h9c4250f491ef987a33540b43edcfac62,
    128'he4b31ca9c908e89580df94fa758f3fa6,
    128'h4707a7fcf37317ba83593c19e6854fa8,
    128'h686b81b27164da8bf8eb0f4b70569d35,
    128'h1e240e5e6358d1a225227c3b01217887,
    128'hd40046579fd327524c3602e7a0c4c89e,
    128'heabf8ad240c738b5a3f7f2cef96115a1,
    128'he0ae5da49b341a55ad933230f58cb1e3,
    128'h1df6e22e8266ca60c02923ab0d534e6f,
    128'hd5db3745defd8e2f03ff6a726d6c5b51,
    128'h8d1baf92bbddbc7f11d95c411f105ad8,
    128'h0ac13188a5cd7bbd2d74d012b8e5b4b0,
    128'h8969974a0c96777e65b9f109c56ec684,
    128'h18f07dec3adc4d2079ee5f3ed7cb3948
  };

  function automatic logic [7:0] rotl(input logic [7:0] x, input int n);
    return (x << n) | (x >> (8 - n));
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, t;
    p = 8'h00;
    t = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ t;
      t = {t[6:0], 1'b0} ^ (t[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  // x^254 == x^-1 in GF(2^8); maps 0 to 0 as AES requires.
  function automatic logic [7:0] gf_inv(input logic [7:0] x);
    logic [7:0] x2, x3, x6, x12, x15, x30, x60, x120, x240, x252;
    x2   = gf_mul(x, x);
    x3   = gf_mul(x2, x);
    x6   = gf_mul(x3, x3);
    x12  = gf_mul(x6, x6);
    x15  = gf_mul(x12, x3);
    x30  = gf_mul(x15, x15);
    x60  = gf_mul(x30, x30);
    x120 = gf_mul(x60, x60);
    x240 = gf_mul(x120, x120);
    x252 = gf_mul(x240, x12);
    return gf_mul(x252, x2);
  endfunction

  logic [7:0] inv_in, inv_out, aff_out, sm4_out;

  // One field inverter serves both AES directions.
  assign inv_in  = (mode_i == MODE_AESI) ?
                   (rotl(x_i, 1) ^ rotl(x_i, 3) ^ rotl(x_i, 6) ^ 8'h05) : x_i;
  assign inv_out = gf_inv(inv_in);
  assign aff_out = inv_out ^ rotl(inv_out, 1) ^ rotl(inv_out, 2) ^
                   rotl(inv_out, 3) ^ rotl(inv_out, 4) ^ 8'h63;
  assign sm4_out = SM4_TAB[{~x_i, 3'b000} +: 8];

  always_comb begin
    case (mode_i)
      MODE_AES:  y_o = aff_out;
      MODE_AESI: y_o = inv_out;
      default:   y_o = sm4_out;
    endcase
  end
endmodule

module riscv_crypto_sbox_seq #(
  parameter int NSBOX = 1
) (
  input  logic        g_clk,
  input  logic        g_reset,
  input  logic        flush,
  input  logic        valid_i,
  output logic        ready_o,
  input  logic        op_aes,
  input  logic        op_sm4,
  input  logic        op_dec,
  input  logic        word_i,
  input  logic [1:0]  bs_i,
  input  logic [31:0] rs_i,
  output logic        valid_o,
  input  logic        ready_i,
  output logic [31:0] result_o,
  output logic        busy_o
);
  generate
    if (!(NSBOX == 1 || NSBOX == 2 || NSBOX == 4)) begin : g_bad_nsbox
      $error("riscv_crypto_sbox_seq: NSBOX must be 1, 2 or 4");
    end
  endgenerate

  localparam int         NGRP     = 4 / NSBOX;
  localparam logic [1:0] LAST_IDX = 2'(NGRP - 1);

  localparam logic [1:0] MODE_NONE = 2'b00;
  localparam logic [1:0] MODE_AES  = 2'b01;
  localparam logic [1:0] MODE_AESI = 2'b10;
  localparam logic [1:0] MODE_SM4  = 2'b11;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  typedef struct packed {
    logic [31:0] rs;
    logic [1:0]  mode;
    logic        word;
    logic [1:0]  bs;
  } req_t;

  state_t     state_q, state_d;
  logic [1:0] idx_q, idx_d;
  req_t       req_q, req_d;
  logic [31:0] res_q, res_d;
  logic [1:0] mode_in;

  logic [NSBOX-1:0][1:0] lane;
  logic [NSBOX-1:0][7:0] sb_in, sb_out;

  always_comb begin
    if (op_aes)      mode_in = op_dec ? MODE_AESI : MODE_AES;
    else if (op_sm4) mode_in = MODE_SM4;
    else             mode_in = MODE_NONE;
  end

  // In byte mode every instance points at bs; only instance 0 is written back.
  for (genvar g = 0; g < NSBOX; g++) begin : g_lane
    assign lane[g]  = req_q.word ? 2'(int'(idx_q) * NSBOX + g) : req_q.bs;
    assign sb_in[g] = req_q.rs[{lane[g], 3'b000} +: 8];
    riscv_crypto_aes_sm4_sbox u_sbox (
      .mode_i (req_q.mode),
      .x_i    (sb_in[g]),
      .y_o    (sb_out[g])
    );
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    req_d   = req_q;
    res_d   = res_q;
    if (flush) begin
      state_d = IDLE;
      idx_d   = 2'd0;
    end else begin
      case (state_q)
        IDLE: if (valid_i) begin
          req_d.rs   = rs_i;
          req_d.mode = mode_in;
          req_d.word = word_i;
          req_d.bs   = bs_i;
          res_d      = 32'h0;
          idx_d      = 2'd0;
          state_d    = RUN;
        end
        RUN: begin
          if (req_q.word) begin
            for (int k = 0; k < NSBOX; k++) res_d[{lane[k], 3'b000} +: 8] = sb_out[k];
          end else begin
            res_d[7:0] = sb_out[0];
          end
          if (!req_q.word || idx_q == LAST_IDX) state_d = DONE;
          else                                  idx_d   = idx_q + 2'd1;
        end
        DONE: if (ready_i) state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge g_clk or posedge g_reset) begin
    if (g_reset) begin
      state_q <= IDLE;
      idx_q   <= 2'd0;
      req_q   <= '0;
      res_q   <= 32'h0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      req_q   <= req_d;
      res_q   <= res_d;
    end
  end

  assign ready_o  = (state_q == IDLE);
  assign valid_o  = (state_q == DONE);
  assign busy_o   = (state_q != IDLE);
  assign result_o = res_q;
endmodule

// File: tb/tb_riscv_crypto_sbox_seq.sv
// Bench for riscv_crypto_sbox_seq: three instances (NSBOX=1,2,4) on shared
// inputs, checked every cycle against a transaction-level reference model.
module tb_riscv_crypto_sbox_seq;
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic        flush = 1'b0, valid_i = 1'b0, ready_i = 1'b1;
  logic        op_aes = 1'b0, op_sm4 = 1'b0, op_dec = 1'b0, word_i = 1'b0;
  logic [1:0]  bs_i = 2'd0;
  logic [31:0] rs_i = 32'h0;
  logic        ready_o [3];
  logic        valid_o [3];
  logic        busy_o  [3];
  logic [31:0] result_o [3];

  int checks = 0;
  int failures = 0;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    riscv_crypto_sbox_seq #(.NSBOX(1 << g)) u_dut (
      .g_clk(clk), .g_reset(rst), .flush(flush), .valid_i(valid_i),
      .ready_o(ready_o[g]), .op_aes(op_aes), .op_sm4(op_sm4), .op_dec(op_dec),
      .word_i(word_i), .bs_i(bs_i), .rs_i(rs_i), .valid_o(valid_o[g]),
      .ready_i(ready_i), .result_o(result_o[g]), .busy_o(busy_o[g])
    );
  end

  logic [7:0] aes_tab [256] = '{
    8'h63,8'h7c,8'h77,8'h7b,8'hf2,8'h6b,8'h6f,8'hc5,8'h30,8'h01,8'h67,8'h2b,8'hfe,8'hd7,8'hab,8'h76,
    8'hca,8'h82,8'hc9,8'h7d,8'hfa,8'h59,8'h47,8'hf0,8'had,8'hd4,8'ha2,8'haf,8'h9c,8'ha4,8'h72,8'hc0,
    8'hb7,8'hfd,8'h93,8'h26,8'h36,8'h3f,8'hf7,8'hcc,8'h34,8'ha5,8'he5,8'hf1,8'h71,8'hd8,8'h31,8'h15,
    8'h04,8'hc7,8'h23,8'hc3,8'h18,8'h96,8'h05,8'h9a,8'h07,8'h12,8'h80,8'he2,8'heb,8'h27,8'hb2,8'h75,
    8'h09,8'h83,8'h2c,8'h1a,8'h1b,8'h6e,8'h5a,8'ha0,8'h52,8'h3b,8'hd6,8'hb3,8'h29,8'he3,8'h2f,8'h84,
    8'h53,8'hd1,8'h00,8'hed,8'h20,8'hfc,8'hb1,8'h5b,8'h6a,8'hcb,8'hbe,8'h39,8'h4a,8'h4c,8'h58,8'hcf,
    8'hd0,8'hef,8'haa,8'hfb,8'h43,8'h4d,8'h33,8'h85,8'h45,8'hf9,8'h02,8'h7f,8'h50,8'h3c,8'h9f,8'ha8,
    8'h51,8'ha3,8'h40,8'h8f,8'h92,8'h9d,8'h38,8'hf5,8'hbc,8'hb6,8'hda,8'h21,8'h10,8'hff,8'hf3,8'hd2,
    8'hcd,8'h0c,8'h13,8'hec,8'h5f,8'h97,8'h44,8'h17,8'hc4,8'ha7,8'h7e,8'h3d,8'h64,8'h5d,8'h19,8'h73,
    8'h60,8'h81,8'h4f,8'hdc,8'h22,8'h2a,8'h90,8'h88,8'h46,8'hee,8'hb8,8'h14,8'hde,8'h5e,8'h0b,8'hdb,
    8'he0,8'h32,8'h3a,8'h0a,8'h49,8'h06,8'h24,8'h5c,8'hc2,8'hd3,8'hac,8'h62,8'h91,8'h95,8'he4,8'h79,
    8'he7,8'hc8,8'h37,8'h6d,8'h8d,8'hd5,8'h4e,8'ha9,8'h6c,8'h56,8'hf4,8'hea,8'h65,8'h7a,8'hae,8'h08,
    8'hba,8'h78,8'h25,8'h2e,8'h1c,8'ha6,8'hb4,8'hc6,8'he8,8'hdd,8'h74,8'h1f,8'h4b,8'hbd,8'h8b,8'h8a,
    8'h70,8'h3e,8'hb5,8'h66,8'h48,8'h03,8'hf6,8'h0e,8'h61,8'h35,8'h57,8'hb9,8'h86,8'hc1,8'h1d,8'h9e,
    8'he1,8'hf8,8'h98,8'h11,8'h69,8'hd9,8'h8e,8'h94,8'h9b,8'h1e,8'h87,8'he9,8'hce,8'h55,8'h28,8'hdf,
    8'h8c,8'ha1,8'h89,8'h0d,8'hbf,8'he6,8'h42,8'h68,8'h41,8'h99,8'h2d,8'h0f,8'hb0,8'h54,8'hbb,8'h16
  };

  logic [7:0] sm4_tab [256] = '{
    8'hd6,8'h90,8'he9,8'hfe,8'hcc,8'he1,8'h3d,8'hb7,8'h16,8'hb6,8'h14,8'hc2,8'h28,8'hfb,8'h2c,8'h05,
    8'h2b,8'h67,8'h9a,8'h76,8'h2a,8'hbe,8'h04,8'hc3,8'haa,8'h44,8'h13,8'h26,8'h49,8'h86,8'h06,8'h99,
    8'h9c,8'h42,8'h50,8'hf4,8'h91,8'hef,8'h98,8'h7a,8'h33,8'h54,8'h0b,8'h43,8'hed,8'hcf,8'hac,8'h62,
    8'he4,8'hb3,8'h1c,8'ha9,8'hc9,8'h08,8'he8,8'h95,8'h80,8'hdf,8'h94,8'hfa,8'h75,8'h8f,8'h3f,8'ha6,
    8'h47,8'h07,8'ha7,8'hfc,8'hf3,8'h73,8'h17,8'hba,8'h83,8'h59,8'h3c,8'h19,8'he6,8'h85,8'h4f,8'ha8,
    8'h68,8'h6b,8'h81,8'hb2,8'h71,8'h64,8'hda,8'h8b,8'hf8,8'heb,8'h0f,8'h4b,8'h70,8'h56,8'h9d,8'h35,
    8'h1e,8'h24,8'h0e,8'h5e,8'h63,8'h58,8'hd1,8'ha2,8'h25,8'h22,8'h7c,8'h3b,8'h01,8'h21,8'h78,8'h87,
    8'hd4,8'h00,8'h46,8'h57,8'h9f,8'hd3,8'h27,8'h52,8'h4c,8'h36,8'h02,8'he7,8'ha0,8'hc4,8'hc8,8'h9e,
    8'hea,8'hbf,8'h8a,8'hd2,8'h40,8'hc7,8'h38,8'hb5,8'ha3,8'hf7,8'hf2,8'hce,8'hf9,8'h61,8'h15,8'ha1,
    8'he0,8'hae,8'h5d,8'ha4,8'h9b,8'h34,8'h1a,8'h55,8'had,8'h93,8'h32,8'h30,8'hf5,8'h8c,8'hb1,8'he3,
    8'h1d,8'hf6,8'he2,8'h2e,8'h82,8'h66,8'hca,8'h60,8'hc0,8'h29,8'h23,8'hab,8'h0d,8'h53,8'h4e,8'h6f,
    8'hd5,8'hdb,8'h37,8'h45,8'hde,8'hfd,8'h8e,8'h2f,8'h03,8'hff,8'h6a,8'h72,8'h6d,8'h6c,8'h5b,8'h51,
    8'h8d,8'h1b,8'haf,8'h92,8'hbb,8'hdd,8'hbc,8'h7f,8'h11,8'hd9,8'h5c,8'h41,8'h1f,8'h10,8'h5a,8'hd8,
    8'h0a,8'hc1,8'h31,8'h88,8'ha5,8'hcd,8'h7b,8'hbd,8'h2d,8'h74,8'hd0,8'h12,8'hb8,8'he5,8'hb4,8'hb0,
    8'h89,8'h69,8'h97,8'h4a,8'h0c,8'h96,8'h77,8'h7e,8'h65,8'hb9,8'hf1,8'h09,8'hc5,8'h6e,8'hc6,8'h84,
    8'h18,8'hf0,8'h7d,8'hec,8'h3a,8'hdc,8'h4d,8'h20,8'h79,8'hee,8'h5f,8'h3e,8'hd7,8'hcb,8'h39,8'h48
  };

  function automatic logic [7:0] aes_inv(input logic [7:0] y);
    for (int i = 0; i < 256; i++) if (aes_tab[i] == y) return 8'(i);
    return 8'h00;
  endfunction

  // m: 0 = AES, 1 = AES^-1, 2 = SM4
  function automatic logic [7:0] sb(input int m, input logic [7:0] x);
    if (m == 0) return aes_tab[x];
    if (m == 1) return aes_inv(x);
    return sm4_tab[x];
  endfunction

  function automatic logic [31:0] ref_op(input logic aes, input logic dec, input logic word,
                                         input logic [1:0] bs, input logic [31:0] rs);
    logic [31:0] r;
    int m;
    m = aes ? (dec ? 1 : 0) : 2;
    r = 32'h0;
    if (word) for (int b = 0; b < 4; b++) r[8*b +: 8] = sb(m, rs[8*b +: 8]);
    else      r[7:0] = sb(m, rs[8*int'(bs) +: 8]);
    return r;
  endfunction

  // Reference model: each instance is idle, running for a fixed number of
  // cycles, or holding a finished result.
  bit          m_run  [3] = '{0, 0, 0};
  bit          m_done [3] = '{0, 0, 0};
  int          m_rem  [3] = '{0, 0, 0};
  logic [31:0] m_res  [3] = '{32'h0, 32'h0, 32'h0};
  logic [31:0] m_pend [3] = '{32'h0, 32'h0, 32'h0};

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int g = 0; g < 3; g++) begin
        m_run[g] <= 1'b0; m_done[g] <= 1'b0; m_rem[g] <= 0; m_res[g] <= 32'h0;
      end
    end else begin
      for (int g = 0; g < 3; g++) begin
        if (flush) begin
          m_run[g] <= 1'b0; m_done[g] <= 1'b0;
        end else if (m_done[g]) begin
          if (ready_i) m_done[g] <= 1'b0;
        end else if (m_run[g]) begin
          m_rem[g] <= m_rem[g] - 1;
          if (m_rem[g] == 1) begin
            m_run[g] <= 1'b0; m_done[g] <= 1'b1; m_res[g] <= m_pend[g];
          end
        end else if (valid_i) begin
          m_run[g]  <= 1'b1;
          m_rem[g]  <= word_i ? (4 >> g) : 1;
          m_pend[g] <= ref_op(op_aes, op_dec, word_i, bs_i, rs_i);
        end
      end
    end
  end

  task automatic chk(input string nm, input int g, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s nsbox=%0d got=%h exp=%h t=%0t", nm, 1 << g, got, exp, $time);
    end
  endtask

  task automatic cmp();
    if (rst) return;
    for (int g = 0; g < 3; g++) begin
      chk("ready_o", g, 32'(ready_o[g]), 32'(!(m_run[g] || m_done[g])));
      chk("valid_o", g, 32'(valid_o[g]), 32'(m_done[g]));
      chk("busy_o",  g, 32'(busy_o[g]),  32'(m_run[g] || m_done[g]));
      if (m_done[g]) chk("result_o", g, result_o[g], m_res[g]);
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    @(negedge clk);
    cmp();
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((busy_o[0] || busy_o[1] || busy_o[2]) && n < 20) begin cycle(); n++; end
    if (n >= 20) chk("idle_timeout", 0, 32'h0, 32'h1);
  endtask

  task automatic set_op(input logic aes, input logic sm4, input logic dec, input logic word,
                        input logic [1:0] bs, input logic [31:0] rs);
    op_aes = aes; op_sm4 = sm4; op_dec = dec; word_i = word; bs_i = bs; rs_i = rs;
  endtask

  task automatic do_op(input string nm, input logic aes, input logic sm4, input logic dec,
                       input logic word, input logic [1:0] bs, input logic [31:0] rs,
                       input logic [31:0] lit);
    bit seen [3];
    int n;
    set_op(aes, sm4, dec, word, bs, rs);
    valid_i = 1'b1;
    cycle();
    valid_i = 1'b0;
    seen = '{0, 0, 0};
    n = 0;
    while (!(seen[0] && seen[1] && seen[2]) && n < 12) begin
      cycle();
      n++;
      for (int g = 0; g < 3; g++) if (!seen[g] && valid_o[g]) begin
        seen[g] = 1'b1;
        chk({nm, "_latency"}, g, 32'(n), word ? 32'(4 >> g) : 32'd1);
        chk({nm, "_result"}, g, result_o[g], lit);
      end
    end
    for (int g = 0; g < 3; g++) if (!seen[g]) chk({nm, "_timeout"}, g, 32'h0, 32'h1);
    wait_idle();
  endtask

  task automatic chk_reset_vals(input string nm);
    for (int g = 0; g < 3; g++) begin
      chk({nm, "_ready"},  g, 32'(ready_o[g]), 32'h1);
      chk({nm, "_valid"},  g, 32'(valid_o[g]), 32'h0);
      chk({nm, "_busy"},   g, 32'(busy_o[g]),  32'h0);
      chk({nm, "_result"}, g, result_o[g],     32'h0);
    end
  endtask

  initial begin
    #2 rst = 1'b1;
    #1 chk_reset_vals("reset");
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    cycle();

    do_op("aes_fwd",  1, 0, 0, 1, 2'd0, 32'h00010253, 32'h637C77ED);
    do_op("aes_inv",  1, 0, 1, 1, 2'd0, 32'h637C77ED, 32'h00010253);
    do_op("sm4_byte", 0, 1, 0, 0, 2'd2, 32'hAA01BBCC, 32'h00000090);
    do_op("sm4_word", 0, 1, 0, 1, 2'd0, 32'h00000000, 32'hD6D6D6D6);
    do_op("noop_sm4", 0, 0, 0, 1, 2'd0, 32'h00000000, 32'hD6D6D6D6);
    do_op("aesi_b3",  1, 1, 1, 0, 2'd3, 32'hED000000, 32'h00000053);
    do_op("aes_b1",   1, 0, 0, 0, 2'd1, 32'h00005300, 32'h000000ED);

    // Backpressure: results parked in DONE while a second request waits.
    ready_i = 1'b0;
    set_op(1, 0, 0, 1, 2'd0, 32'h00010253);
    valid_i = 1'b1;
    cycle();
    rs_i = 32'h0;
    repeat (4) cycle();
    repeat (5) begin
      cycle();
      for (int g = 0; g < 3; g++) begin
        chk("bp_valid",  g, 32'(valid_o[g]), 32'h1);
        chk("bp_ready",  g, 32'(ready_o[g]), 32'h0);
        chk("bp_result", g, result_o[g], 32'h637C77ED);
      end
    end
    valid_i = 1'b0;
    ready_i = 1'b1;
    wait_idle();

    // Flush during the second RUN cycle of the NSBOX=1 instance.
    set_op(1, 0, 0, 1, 2'd0, 32'h00010253);
    valid_i = 1'b1;
    cycle();
    valid_i = 1'b0;
    cycle();
    flush = 1'b1;
    cycle();
    flush = 1'b0;
    chk("flush_busy", 0, 32'(busy_o[0]), 32'h0);
    repeat (6) begin
      cycle();
      chk("flush_novalid", 0, 32'(valid_o[0]), 32'h0);
    end

    // Request offered together with flush must not be taken.
    flush = 1'b1;
    valid_i = 1'b1;
    cycle();
    flush = 1'b0;
    valid_i = 1'b0;
    for (int g = 0; g < 3; g++) chk("flush_noaccept", g, 32'(busy_o[g]), 32'h0);
    cycle();

    // Asynchronous reset in the middle of a word op.
    set_op(1, 0, 0, 1, 2'd0, 32'h00010253);
    valid_i = 1'b1;
    cycle();
    valid_i = 1'b0;
    cycle();
    #2 rst = 1'b1;
    #1 chk_reset_vals("async_rst");
    @(negedge clk);
    rst = 1'b0;
    cycle();

    repeat (20000) begin
      valid_i = $urandom_range(0, 3) != 0;
      ready_i = $urandom_range(0, 3) != 0;
      flush   = $urandom_range(0, 49) == 0;
      op_aes  = 1'($urandom_range(0, 1));
      op_sm4  = 1'($urandom_range(0, 1));
      op_dec  = 1'($urandom_range(0, 1));
      word_i  = 1'($urandom_range(0, 1));
      bs_i    = 2'($urandom_range(0, 3));
      rs_i    = $urandom;
      cycle();
    end
    valid_i = 1'b0;
    flush = 1'b0;
    ready_i = 1'b1;
    wait_idle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #5000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end
endmodule
